// File: rtl/rng_pkg.sv
// rng_pkg: shared LFSR width, default seed, arbiter states and LFSR step function
package rng_pkg;

    localparam int LFSR_W = 4;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 4'b1010;

    typedef enum logic {ST_WARMUP, ST_READY} state_e;

    // x^4+x^3+1 Fibonacci step; period 15, never reaches zero from a nonzero value
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[2:0], v[3] ^ v[2]};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin one-hot picker, searching upward from ptr_i with wrap
module rr_pick
    import rng_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  sel_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    // first eligible bit at or after the pointer wins; only the first hit is taken
    always_comb begin
        sel_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!valid_o && elig_i[idx]) begin
                sel_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: round-robin shared 4-bit LFSR source; RNG_GRANT_CNT_EN adds a saturating grant counter
module lfsr_rng_arbiter
    import rng_pkg::*;
#(
    parameter int                NREQ          = 4,
    parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED,
    parameter int                WARMUP_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              seed_load_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [LFSR_W-1:0] value_o,
    output logic              busy_o
`ifdef RNG_GRANT_CNT_EN
    ,
    output logic [7:0]        grant_cnt_o
`endif
);

    localparam int     PW      = $clog2(NREQ);
    localparam logic [3:0] WU  = 4'(WARMUP_CYCLES);
    localparam state_e ST_INIT = (WARMUP_CYCLES == 0) ? ST_READY : ST_WARMUP;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [LFSR_W-1:0] val_q, val_d;
    logic [NREQ-1:0]   sel;
    logic              sel_valid;
    logic [PW-1:0]     sel_idx;
    logic [PW-1:0]     ptr_nxt;

    // the requester granted this cycle sits out the next decision
    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .elig_i  (req_i & ~gnt_q),
        .ptr_i   (ptr_q),
        .sel_o   (sel),
        .valid_o (sel_valid)
    );

    // one-hot to index, and the pointer moves just past the winner
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (sel[i]) sel_idx = PW'(i);
        ptr_nxt = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
    end

    // next state: reseed beats everything, then warm-up stepping, then a grant
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        val_d   = '0;
        if (seed_load_i) begin
            lfsr_d  = (seed_i == '0) ? SEED : seed_i;
            cnt_d   = WU;
            state_d = ST_INIT;
        end else if (state_q == ST_WARMUP) begin
            lfsr_d  = lfsr_next(lfsr_q);
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? ST_READY : ST_WARMUP;
        end else if (sel_valid) begin
            gnt_d  = sel;
            val_d  = lfsr_q;
            lfsr_d = lfsr_next(lfsr_q);
            ptr_d  = ptr_nxt;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= WU;
            lfsr_q  <= SEED;
            ptr_q   <= '0;
            gnt_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            val_q   <= val_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign value_o = val_q;
    assign busy_o  = (state_q == ST_WARMUP);

`ifdef RNG_GRANT_CNT_EN
    logic [7:0] gcnt_q, gcnt_d;

    // counts cycles with a grant on the output, sticking at 255
    always_comb gcnt_d = seed_load_i ? 8'd0 : ((|gnt_q) && gcnt_q != 8'hFF) ? gcnt_q + 8'd1 : gcnt_q;

    // grant counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) gcnt_q <= 8'd0;
        else       gcnt_q <= gcnt_d;
    end

    assign grant_cnt_o = gcnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb_lfsr_rng_arbiter: scenario tasks plus randomized run against a cycle-level reference model
module tb_lfsr_rng_arbiter;

    localparam int NREQ = 4;
    localparam int SEED = 10;
    localparam int WU   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] seed;
    logic       seed_load;
    logic [3:0] gnt;
    logic [3:0] val;
    logic       busy;
`ifdef RNG_GRANT_CNT_EN
    logic [7:0] gcnt;
`endif

    int checks   = 0;
    int failures = 0;

    int         m_lfsr, m_warm, m_ptr, m_cnt;
    logic [3:0] exp_gnt, exp_val;
    logic       exp_busy;

    lfsr_rng_arbiter #(.NREQ(NREQ), .SEED(4'b1010), .WARMUP_CYCLES(WU)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .seed_i      (seed),
        .seed_load_i (seed_load),
        .gnt_o       (gnt),
        .value_o     (val),
        .busy_o      (busy)
`ifdef RNG_GRANT_CNT_EN
        ,
        .grant_cnt_o (gcnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int lfsr_step(input int v);
        return ((v * 2) % 16) + (((v / 8) ^ (v / 4)) % 2);
    endfunction

    task automatic tick();
        int k;
        int found;
        logic [3:0] elig;
        if (rst || seed_load) m_cnt = 0;
        else if (exp_gnt != 0 && m_cnt < 255) m_cnt++;
        if (rst) begin
            m_lfsr = SEED; m_warm = WU; m_ptr = 0; exp_gnt = 0; exp_val = 0;
        end else if (seed_load) begin
            m_lfsr = (seed == 0) ? SEED : int'(seed); m_warm = WU; exp_gnt = 0; exp_val = 0;
        end else if (m_warm > 0) begin
            m_lfsr = lfsr_step(m_lfsr); m_warm--; exp_gnt = 0; exp_val = 0;
        end else begin
            elig  = req & ~exp_gnt;
            found = -1;
            for (int o = 0; o < NREQ; o++) begin
                k = (m_ptr + o) % NREQ;
                if (found < 0 && elig[k]) found = k;
            end
            if (found >= 0) begin
                exp_gnt = 4'(1 << found);
                exp_val = 4'(m_lfsr);
                m_lfsr  = lfsr_step(m_lfsr);
                m_ptr   = (found + 1) % NREQ;
            end else begin
                exp_gnt = 0; exp_val = 0;
            end
        end
        exp_busy = (m_warm > 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; seed_load = 1'b0; req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; seed_load = 1'b0; req = 4'hF;
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (val !== 4'b0000) begin failures++; $display("FAIL reset_val got=%b exp=0000", val); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        rst = 1'b0; req = '0;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL warm2_busy got=%b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0 || busy !== exp_busy) begin failures++; $display("FAIL ready_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        logic [3:0] vals [3];
        int         cyc [3];
        int         n = 0;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 30 && n < 3; c++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt || val !== exp_val) begin
                failures++; $display("FAIL single_model gnt=%b val=%b exp_gnt=%b exp_val=%b", gnt, val, exp_gnt, exp_val);
            end
            if (gnt != 0) begin vals[n] = val; cyc[n] = c; n++; end
        end
        checks++; if (n != 3) begin failures++; $display("FAIL single_timeout grants=%0d exp=3", n); end
        if (n == 3) begin
            checks++; if (vals[0] !== 4'b1011) begin failures++; $display("FAIL single_v0 got=%b exp=1011", vals[0]); end
            checks++; if (vals[1] !== 4'b0111) begin failures++; $display("FAIL single_v1 got=%b exp=0111", vals[1]); end
            checks++; if (vals[2] !== 4'b1111) begin failures++; $display("FAIL single_v2 got=%b exp=1111", vals[2]); end
            checks++; if (cyc[1] - cyc[0] != 2 || cyc[2] - cyc[1] != 2) begin failures++; $display("FAIL single_gap got=%0d,%0d exp=2,2", cyc[1] - cyc[0], cyc[2] - cyc[1]); end
        end
    endtask

    task automatic test_all_req();
        logic [3:0] g_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] v_tab [5] = '{4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
        logic [15:0] seen = '0;
        int n = 0;
        int dup = 0;
        do_reset();
        req = 4'hF;
        for (int c = 0; c < 40 && n < 15; c++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt || val !== exp_val) begin
                failures++; $display("FAIL allreq_model gnt=%b val=%b exp_gnt=%b exp_val=%b", gnt, val, exp_gnt, exp_val);
            end
            if (gnt != 0) begin
                if (n < 5) begin
                    checks++;
                    if (gnt !== g_tab[n] || val !== v_tab[n]) begin
                        failures++; $display("FAIL allreq_seq%0d gnt=%b val=%b exp_gnt=%b exp_val=%b", n, gnt, val, g_tab[n], v_tab[n]);
                    end
                end
                if (seen[val] || val == 0) dup++;
                seen[val] = 1'b1;
                n++;
            end
        end
        checks++; if (n != 15 || dup != 0) begin failures++; $display("FAIL allreq_unique grants=%0d repeats=%0d exp=15,0", n, dup); end
    endtask

    task automatic test_seed_zero();
        int n = 0;
        seed = 4'b0000; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL seed0_load gnt=%b busy=%b exp=0000,1", gnt, busy); end
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL seed0_warm got=%b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seed0_ready got=%b exp=0", busy); end
        for (int c = 0; c < 5 && gnt == 0; c++) tick();
        checks++; if (gnt == 0 || val !== 4'b1011) begin failures++; $display("FAIL seed0_value gnt=%b val=%b exp_val=1011", gnt, val); end
    endtask

    task automatic test_seed_same_cycle();
        req = '0;
        tick(); tick();
        req = 4'b0010; seed = 4'b0001; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL seedsc_nogrant%0d got=%b exp=0000", c, gnt); end
            tick();
        end
        checks++; if (gnt !== 4'b0010 || val !== 4'b0100) begin failures++; $display("FAIL seedsc_grant gnt=%b val=%b exp=0010,0100", gnt, val); end
    endtask

    task automatic test_reset_mid();
        req = 4'hF;
        for (int c = 0; c < 20 && gnt !== 4'b0001; c++) tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_wait gnt=%b exp=0001", gnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1001;
        checks++; if (gnt !== 4'b0000 || val !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_reset gnt=%b val=%b busy=%b exp=0000,0000,1", gnt, val, busy); end
        for (int c = 0; c < 10 && gnt == 0; c++) tick();
        checks++; if (gnt !== 4'b0001 || val !== 4'b1011) begin failures++; $display("FAIL rstmid_first gnt=%b val=%b exp=0001,1011", gnt, val); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req       = 4'($urandom);
            seed      = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            seed_load = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (gnt !== exp_gnt || val !== exp_val || busy !== exp_busy || !$onehot0(gnt)) begin
                failures++; $display("FAIL random_c%0d gnt=%b val=%b busy=%b exp=%b,%b,%b", c, gnt, val, busy, exp_gnt, exp_val, exp_busy);
            end
`ifdef RNG_GRANT_CNT_EN
            checks++; if (int'(gcnt) != m_cnt) begin failures++; $display("FAIL random_cnt_c%0d got=%0d exp=%0d", c, gcnt, m_cnt); end
`endif
        end
        rst = 1'b0; seed_load = 1'b0;
    endtask

`ifdef RNG_GRANT_CNT_EN
    task automatic test_grant_cnt();
        do_reset();
        req = 4'hF;
        for (int c = 0; c < 310; c++) tick();
        checks++; if (gcnt !== 8'd255 || int'(gcnt) != m_cnt) begin failures++; $display("FAIL gcnt_sat got=%0d exp=255", gcnt); end
        seed = 4'b0110; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checks++; if (gcnt !== 8'd0) begin failures++; $display("FAIL gcnt_clear got=%0d exp=0", gcnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; seed = '0; seed_load = 1'b0;
        exp_gnt = '0; exp_val = '0; exp_busy = 1'b1;
        m_lfsr = SEED; m_warm = WU; m_ptr = 0; m_cnt = 0;
        test_reset();
        test_single();
        test_all_req();
        test_seed_zero();
        test_seed_same_cycle();
        test_reset_mid();
        test_random();
`ifdef RNG_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
